regfile_sb: RTL and testbench

Parametrised integer register file for the RV32 core, successor to the single-write 2-read register file.
- Configurable read-port count and register width/depth.
- Two write ports: ALU writeback and load return.
- Same-cycle write-to-read bypass.
- Per-register pending scoreboard, so decode can stall on outstanding loads.
- Sits between decode (reads, reservations) and writeback/LSU (writes).

---
 rtl/regfile_sb.sv | 113 +++++++++++
 tb/tb_regfile_sb.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Integer register file with two write ports, same-cycle write-to-read bypass
// and a per-register pending scoreboard for outstanding loads.

module regfile_sb_rdport #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] stored,
    input  logic            pend,
    input  logic            ld_wren,
    input  logic [AW-1:0]   ld_addr,
    input  logic [XLEN-1:0] ld_data,
    input  logic            wb_wren,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] data,
    output logic            busy
);
    logic is_zero, ld_hit, wb_hit;

    always_comb begin
        is_zero = (ZERO_REG != 0) && (addr == '0);
        ld_hit  = ld_wren && (ld_addr == addr);
        wb_hit  = wb_wren && (wb_addr == addr);
        // load return beats ALU writeback, matching the write-port priority
        if (is_zero)     data = '0;
        else if (ld_hit) data = ld_data;
        else if (wb_hit) data = wb_data;
        else             data = stored;
        busy = pend && !ld_hit && !is_zero;
    end
endmodule

module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG),
    localparam int CW      = $clog2(NREG + 1)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NRD*AW-1:0]   i_rs_addr,
    output logic [NRD*XLEN-1:0] o_rs_data,
    output logic [NRD-1:0]      o_rs_busy,
    input  logic                i_wb_wren,
    input  logic [AW-1:0]       i_wb_addr,
    input  logic [XLEN-1:0]     i_wb_data,
    input  logic                i_ld_wren,
    input  logic [AW-1:0]       i_ld_addr,
    input  logic [XLEN-1:0]     i_ld_data,
    input  logic                i_rsv_en,
    input  logic [AW-1:0]       i_rsv_addr,
    output logic                o_rsv_conflict,
    output logic [CW-1:0]       o_pending_cnt,
    output logic                o_err_waw
);
    logic [NREG-1:0][XLEN-1:0] regs;
    logic [NREG-1:0]           pending, pend_nxt;
    logic [CW-1:0]             cnt_nxt;
    logic                      wb_we, ld_we, rsv_ok, waw;

    always_comb begin
        wb_we  = i_wb_wren && !((ZERO_REG != 0) && (i_wb_addr == '0));
        ld_we  = i_ld_wren && !((ZERO_REG != 0) && (i_ld_addr == '0));
        rsv_ok = i_rsv_en && !((ZERO_REG != 0) && (i_rsv_addr == '0));
        waw    = wb_we && ld_we && (i_wb_addr == i_ld_addr);
        // set after clear so a same-cycle reservation wins over the load return
        pend_nxt = pending;
        if (ld_we)  pend_nxt[i_ld_addr]  = 1'b0;
        if (rsv_ok) pend_nxt[i_rsv_addr] = 1'b1;
        o_rsv_conflict = rsv_ok && pending[i_rsv_addr] &&
                         !(ld_we && (i_ld_addr == i_rsv_addr));
        cnt_nxt = '0;
        for (int r = 0; r < NREG; r++) cnt_nxt = cnt_nxt + CW'(pend_nxt[r]);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            regs          <= '0;
            pending       <= '0;
            o_pending_cnt <= '0;
            o_err_waw     <= 1'b0;
        end else begin
            if (wb_we) regs[i_wb_addr] <= i_wb_data;
            if (ld_we) regs[i_ld_addr] <= i_ld_data;
            pending       <= pend_nxt;
            o_pending_cnt <= cnt_nxt;
            o_err_waw     <= waw;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] a;
        assign a = i_rs_addr[k*AW +: AW];
        regfile_sb_rdport #(.XLEN(XLEN), .AW(AW), .ZERO_REG(ZERO_REG)) u_rd (
            .addr    (a),
            .stored  (regs[a]),
            .pend    (pending[a]),
            .ld_wren (i_ld_wren),
            .ld_addr (i_ld_addr),
            .ld_data (i_ld_data),
            .wb_wren (i_wb_wren),
            .wb_addr (i_wb_addr),
            .wb_data (i_wb_data),
            .data    (o_rs_data[k*XLEN +: XLEN]),
            .busy    (o_rs_busy[k])
        );
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table, hand sequences and a randomized
// run checked against an array-based model of the register file rules.

module tb_regfile_sb;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [9:0]  i_rs_addr;
    logic [63:0] o_rs_data;
    logic [1:0]  o_rs_busy;
    logic        i_wb_wren, i_ld_wren, i_rsv_en;
    logic [4:0]  i_wb_addr, i_ld_addr, i_rsv_addr;
    logic [31:0] i_wb_data, i_ld_data;
    logic        o_rsv_conflict, o_err_waw;
    logic [5:0]  o_pending_cnt;

    int total = 0;
    int bad   = 0;

    bit [31:0] m_reg [32];
    bit        m_pend[32];
    int        m_cnt;
    bit        m_err;

    regfile_sb #(.XLEN(32), .NREG(32), .NRD(2), .ZERO_REG(1)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_rs_addr(i_rs_addr),
        .o_rs_data(o_rs_data), .o_rs_busy(o_rs_busy),
        .i_wb_wren(i_wb_wren), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .i_ld_wren(i_ld_wren), .i_ld_addr(i_ld_addr), .i_ld_data(i_ld_data),
        .i_rsv_en(i_rsv_en), .i_rsv_addr(i_rsv_addr),
        .o_rsv_conflict(o_rsv_conflict), .o_pending_cnt(o_pending_cnt),
        .o_err_waw(o_err_waw)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit rst; bit wbe; bit [4:0] wba; bit [31:0] wbd;
        bit lde; bit [4:0] lda; bit [31:0] ldd;
        bit rsv; bit [4:0] rsa; bit [4:0] r0; bit [4:0] r1;
        bit [31:0] e0; bit [31:0] e1; bit [1:0] ebusy; bit econf; int ecnt; bit eerr;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        i_rst = 0; i_wb_wren = 0; i_ld_wren = 0; i_rsv_en = 0;
        i_wb_addr = 0; i_ld_addr = 0; i_rsv_addr = 0;
        i_wb_data = 0; i_ld_data = 0;
    endtask

    // model read of one port, straight from the read priority rules
    function automatic bit [31:0] m_read(input bit [4:0] a);
        if (a == 0) return 0;
        if (i_ld_wren && i_ld_addr == a) return i_ld_data;
        if (i_wb_wren && i_wb_addr == a) return i_wb_data;
        return m_reg[a];
    endfunction

    function automatic bit m_busy(input bit [4:0] a);
        return a != 0 && m_pend[a] && !(i_ld_wren && i_ld_addr == a);
    endfunction

    task automatic check_model();
        bit [4:0] a0, a1;
        a0 = i_rs_addr[4:0];
        a1 = i_rs_addr[9:5];
        chk("m_data0", o_rs_data[31:0],  m_read(a0));
        chk("m_data1", o_rs_data[63:32], m_read(a1));
        chk("m_busy",  o_rs_busy, {m_busy(a1), m_busy(a0)});
        chk("m_conf",  o_rsv_conflict, i_rsv_en && i_rsv_addr != 0 && m_pend[i_rsv_addr] &&
                       !(i_ld_wren && i_ld_addr == i_rsv_addr));
        chk("m_cnt",   o_pending_cnt, m_cnt);
        chk("m_err",   o_err_waw, m_err);
    endtask

    // advance model and DUT by one clock using the current inputs
    task automatic tick();
        if (i_rst) begin
            foreach (m_reg[r]) begin m_reg[r] = 0; m_pend[r] = 0; end
            m_err = 0;
        end else begin
            m_err = i_wb_wren && i_ld_wren && i_wb_addr == i_ld_addr && i_wb_addr != 0;
            if (i_wb_wren && i_wb_addr != 0) m_reg[i_wb_addr] = i_wb_data;
            if (i_ld_wren && i_ld_addr != 0) begin
                m_reg[i_ld_addr]  = i_ld_data;
                m_pend[i_ld_addr] = 0;
            end
            if (i_rsv_en && i_rsv_addr != 0) m_pend[i_rsv_addr] = 1;
        end
        m_cnt = 0;
        foreach (m_pend[r]) m_cnt += m_pend[r];
        @(posedge i_clk);
        #1;
    endtask

    function automatic vec_t mk(bit wbe, bit [4:0] wba, bit [31:0] wbd,
                                bit lde, bit [4:0] lda, bit [31:0] ldd,
                                bit rsv, bit [4:0] rsa, bit [4:0] r0, bit [4:0] r1,
                                bit [31:0] e0, bit [31:0] e1, bit [1:0] eb,
                                bit ec, int en, bit ee);
        vec_t v;
        v.rst = 0; v.wbe = wbe; v.wba = wba; v.wbd = wbd; v.lde = lde; v.lda = lda;
        v.ldd = ldd; v.rsv = rsv; v.rsa = rsa; v.r0 = r0; v.r1 = r1; v.e0 = e0;
        v.e1 = e1; v.ebusy = eb; v.econf = ec; v.ecnt = en; v.eerr = ee;
        return v;
    endfunction

    vec_t tbl[16];

    initial begin
        tbl[0]  = mk(0,0,0,          0,0,0,       0,0, 5,31, 0,0,                   2'b00,0,0,0);
        tbl[1]  = mk(1,5,32'hDEADBEEF,0,0,0,      0,0, 5,31, 32'hDEADBEEF,0,        2'b00,0,0,0);
        tbl[2]  = mk(0,0,0,          0,0,0,       0,0, 5,31, 32'hDEADBEEF,0,        2'b00,0,0,0);
        tbl[3]  = mk(1,7,32'h1111,   1,7,32'h2222,0,0, 7,5,  32'h2222,32'hDEADBEEF, 2'b00,0,0,0);
        tbl[4]  = mk(1,0,32'h55,     1,0,32'h66,  0,0, 7,0,  32'h2222,0,            2'b00,0,0,1);
        tbl[5]  = mk(0,0,0,          0,0,0,       0,0, 7,0,  32'h2222,0,            2'b00,0,0,0);
        tbl[6]  = mk(0,0,0,          0,0,0,       1,9, 9,7,  0,32'h2222,            2'b00,0,0,0);
        tbl[7]  = mk(0,0,0,          0,0,0,       1,9, 9,7,  0,32'h2222,            2'b01,1,1,0);
        tbl[8]  = mk(0,0,0,          1,9,32'hABCD,0,0, 9,9,  32'hABCD,32'hABCD,     2'b00,0,1,0);
        tbl[9]  = mk(0,0,0,          0,0,0,       0,0, 9,7,  32'hABCD,32'h2222,     2'b00,0,0,0);
        tbl[10] = mk(0,0,0,          1,3,32'h77,  1,3, 3,9,  32'h77,32'hABCD,       2'b00,0,0,0);
        tbl[11] = mk(0,0,0,          0,0,0,       0,0, 3,9,  32'h77,32'hABCD,       2'b01,0,1,0);
        tbl[12] = mk(0,0,0,          1,3,32'h88,  1,3, 3,9,  32'h88,32'hABCD,       2'b00,0,1,0);
        tbl[13] = mk(0,0,0,          0,0,0,       0,0, 3,9,  32'h88,32'hABCD,       2'b01,0,1,0);
        tbl[14] = mk(0,0,0,          0,0,0,       1,0, 0,3,  0,32'h88,              2'b10,0,1,0);
        tbl[15] = mk(0,0,0,          0,0,0,       0,0, 0,3,  0,32'h88,              2'b10,0,1,0);

        idle();
        i_rs_addr = 0;
        i_rst = 1;
        tick();
        tick();
        i_rst = 0;

        foreach (tbl[i]) begin
            i_wb_wren = tbl[i].wbe; i_wb_addr = tbl[i].wba; i_wb_data = tbl[i].wbd;
            i_ld_wren = tbl[i].lde; i_ld_addr = tbl[i].lda; i_ld_data = tbl[i].ldd;
            i_rsv_en  = tbl[i].rsv; i_rsv_addr = tbl[i].rsa;
            i_rs_addr = {tbl[i].r1, tbl[i].r0};
            #2;
            chk($sformatf("v%0d_data0", i), o_rs_data[31:0],  tbl[i].e0);
            chk($sformatf("v%0d_data1", i), o_rs_data[63:32], tbl[i].e1);
            chk($sformatf("v%0d_busy", i),  o_rs_busy, tbl[i].ebusy);
            chk($sformatf("v%0d_conf", i),  o_rsv_conflict, tbl[i].econf);
            chk($sformatf("v%0d_cnt", i),   o_pending_cnt, tbl[i].ecnt);
            chk($sformatf("v%0d_err", i),   o_err_waw, tbl[i].eerr);
            check_model();
            tick();
        end

        // fill the scoreboard x1..x31 (x3 is already pending), saturating at NREG-1
        idle();
        for (int r = 1; r < 32; r++) begin
            i_rsv_en = 1; i_rsv_addr = 5'(r); i_rs_addr = {5'(r), 5'(r)};
            #2;
            check_model();
            tick();
        end
        idle();
        #2;
        chk("full_cnt", o_pending_cnt, 6'd31);
        check_model();

        // reset beats same-cycle writes and reservations
        i_rst = 1; i_rsv_en = 1; i_rsv_addr = 16;
        i_wb_wren = 1; i_wb_addr = 5; i_wb_data = 32'h1234;
        i_ld_wren = 1; i_ld_addr = 6; i_ld_data = 32'h5678;
        tick();
        idle();
        #2;
        chk("rst_cnt", o_pending_cnt, 6'd0);
        chk("rst_err", o_err_waw, 1'b0);
        for (int r = 0; r < 32; r++) begin
            i_rs_addr = {5'(31 - r), 5'(r)};
            #1;
            chk($sformatf("rst_x%0d_data", r), o_rs_data, 64'd0);
            chk($sformatf("rst_x%0d_busy", r), o_rs_busy, 2'b00);
        end

        // randomized traffic on a narrow address window to force collisions
        for (int n = 0; n < 1500; n++) begin
            bit [4:0] mask;
            mask = ($urandom_range(0, 3) == 0) ? 5'h1F : 5'h07;
            i_rst      = ($urandom_range(0, 99) == 0);
            i_wb_wren  = $urandom_range(0, 1);
            i_wb_addr  = 5'($urandom) & mask;
            i_wb_data  = $urandom;
            i_ld_wren  = $urandom_range(0, 2) == 0;
            i_ld_addr  = 5'($urandom) & mask;
            i_ld_data  = $urandom;
            i_rsv_en   = $urandom_range(0, 2) == 0;
            i_rsv_addr = 5'($urandom) & mask;
            i_rs_addr  = {5'($urandom) & mask, 5'($urandom) & mask};
            #2;
            check_model();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
